mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-requester memory arbiter.
//   state_e    - arbiter FSM states (idle, issue, wait)
//   req_id_e   - requester identity (REQ_IF = fetch, REQ_D = data stage)
//   DataWidth  - width of the memory data bus
package mem_arbiter_pkg;

   localparam int unsigned DataWidth = 32;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   typedef enum logic {
      REQ_IF,
      REQ_D
   } req_id_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto a single-ported memory
// with a fixed read latency. At most one access is outstanding.
//
// Timing for a request seen in idle on cycle t:
//   t+1              : gnt, mem_en, mem_we/mem_addr/mem_wdata
//   t+1+MEM_LATENCY  : mem_rdata valid, captured into the winner's rdata
//   t+2+MEM_LATENCY  : winner's rvalid, FSM back in idle
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   if_req/if_addr           - fetch read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata- fetch grant, completion, read data
//   d_req/d_we/d_addr/d_wdata- data-stage load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata   - data grant, completion, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory port
//
// Build option: define MEM_ARBITER_STARVE_EN to let a waiting fetch win a tie after
// STARVE_LIMIT consecutive data grants. Without it, data always wins a tie.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned MEM_LATENCY  = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DataWidth-1:0]  if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DataWidth-1:0]  d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DataWidth-1:0]  d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DataWidth-1:0]  mem_wdata,
   input  logic [DataWidth-1:0]  mem_rdata
);

   if (MEM_LATENCY == 0 || MEM_LATENCY > 8 || STARVE_LIMIT == 0) begin : g_param_check
      $error("mem_arbiter: MEM_LATENCY must be 1..8 and STARVE_LIMIT at least 1");
   end

   // Wait-counter value on the cycle mem_rdata is valid.
   localparam logic [3:0] LastCnt = 4'(MEM_LATENCY - 1);

   state_e                state_q, state_d;
   req_id_e               winner_q, winner_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DataWidth-1:0]  wdata_q, wdata_d;
   logic [3:0]            lat_cnt_q, lat_cnt_d;
   logic                  if_rvalid_q, if_rvalid_d;
   logic                  d_rvalid_q, d_rvalid_d;
   logic [DataWidth-1:0]  if_rdata_q, if_rdata_d;
   logic [DataWidth-1:0]  d_rdata_q, d_rdata_d;
   logic                  fetch_wins;

`ifdef MEM_ARBITER_STARVE_EN
   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

   logic [StarveW-1:0] starve_q, starve_d;

   assign fetch_wins = if_req && (!d_req || (starve_q >= StarveW'(STARVE_LIMIT)));

   // Counts data grants that overtook a waiting fetch; any gap in if_req restarts it.
   always_comb begin
      starve_d = starve_q;
      if (!if_req || if_gnt) begin
         starve_d = '0;
      end else if (d_gnt && (starve_q < StarveW'(STARVE_LIMIT))) begin
         starve_d = starve_q + StarveW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign fetch_wins = if_req && !d_req;
`endif

   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lat_cnt_d   = lat_cnt_q;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (if_req || d_req) begin
               state_d = StIssue;
               if (fetch_wins) begin
                  winner_d = REQ_IF;
                  we_d     = 1'b0;
                  addr_d   = if_addr;
                  wdata_d  = '0;
               end else begin
                  winner_d = REQ_D;
                  we_d     = d_we;
                  addr_d   = d_addr;
                  wdata_d  = d_wdata;
               end
            end
         end
         StIssue: begin
            lat_cnt_d = '0;
            state_d   = StWait;
         end
         StWait: begin
            if (lat_cnt_q == LastCnt) begin
               state_d = StIdle;
               if (winner_q == REQ_IF) begin
                  if_rdata_d  = mem_rdata;
                  if_rvalid_d = 1'b1;
               end else begin
                  // Stores complete without disturbing the last load data.
                  if (!we_q) begin
                     d_rdata_d = mem_rdata;
                  end
                  d_rvalid_d = 1'b1;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         winner_q    <= REQ_D;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lat_cnt_q   <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lat_cnt_q   <= lat_cnt_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign mem_en    = (state_q == StIssue);
   assign mem_we    = mem_en && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_gnt    = mem_en && (winner_q == REQ_IF);
   assign d_gnt     = mem_en && (winner_q == REQ_D);
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (ADDR_WIDTH=16, MEM_LATENCY=2).
// Directed scenarios push cycle-stamped expected events (grants, completions); a
// monitor pops and compares whenever the DUT raises a gnt or rvalid strobe.
module tb_mem_arbiter;

   localparam int MemLatency = 2;
`ifdef MEM_ARBITER_STARVE_EN
   localparam bit StarveEn = 1'b1;
`else
   localparam bit StarveEn = 1'b0;
`endif

   localparam int KIfGnt = 0;
   localparam int KDGnt  = 1;
   localparam int KIfRv  = 2;
   localparam int KDRv   = 3;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   mem_arbiter #(
      .ADDR_WIDTH  (16),
      .MEM_LATENCY (MemLatency),
      .STARVE_LIMIT(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      int          cyc;
      int          kind;
      logic [15:0] addr;
      logic        we;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic [31:0] d_last = 32'h0;

   function automatic logic [31:0] mem_f(input logic [15:0] a);
      return {a ^ 16'h5A5A, ~a};
   endfunction

   task automatic push(input int c, input int k, input logic [15:0] a, input logic we,
                       input logic [31:0] d);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      e.addr = a;
      e.we   = we;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic check_event(input int k);
      exp_t e;
      logic ok;
      logic [31:0] got;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL event_unexpected kind=%0d at cycle %0d, required no event", k, cyc);
         return;
      end
      e   = exp_q.pop_front();
      ok  = (e.kind == k) && (e.cyc == cyc);
      got = 32'h0;
      case (k)
         KIfGnt: begin
            got = {16'h0, mem_addr};
            ok  = ok && mem_en && !mem_we && (mem_addr == e.addr);
         end
         KDGnt: begin
            got = {16'h0, mem_addr};
            ok  = ok && mem_en && (mem_we == e.we) && (mem_addr == e.addr) &&
                  (!e.we || (mem_wdata == e.data));
         end
         KIfRv: begin
            got = if_rdata;
            ok  = ok && (if_rdata == e.data);
         end
         default: begin
            got = d_rdata;
            ok  = ok && (d_rdata == e.data);
         end
      endcase
      if (!ok) begin
         failures++;
         $display("FAIL event kind=%0d cyc=%0d val=%h we=%b wdata=%h, required kind=%0d cyc=%0d addr=%h we=%b data=%h",
                  k, cyc, got, mem_we, mem_wdata, e.kind, e.cyc, e.addr, e.we, e.data);
      end
   endtask

   task automatic settle(input string name);
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s pending_events=%0d required=0 (next kind=%0d cyc=%0d)",
                  name, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
         exp_q.delete();
      end
   endtask

   task automatic sync(output int c);
      @(posedge clk);
      #1;
      c = cyc;
   endtask

   task automatic issue_if(input logic [15:0] a);
      int n;
      n       = 0;
      if_addr = a;
      if_req  = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!if_gnt && n < 50);
      if (!if_gnt) begin
         checks++;
         failures++;
         $display("FAIL if_gnt_timeout addr=%h gnt=0 required=1", a);
      end
      @(posedge clk);
      #1;
      if_req = 1'b0;
   endtask

   task automatic issue_d(input logic [15:0] a, input logic we, input logic [31:0] wd);
      int n;
      n       = 0;
      d_addr  = a;
      d_we    = we;
      d_wdata = wd;
      d_req   = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!d_gnt && n < 50);
      if (!d_gnt) begin
         checks++;
         failures++;
         $display("FAIL d_gnt_timeout addr=%h gnt=0 required=1", a);
      end
      @(posedge clk);
      #1;
      d_req = 1'b0;
   endtask

   task automatic check_idle_outputs(input string name);
      logic [161:0] got;
      @(negedge clk);
      got = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_addr, mem_wdata,
             if_rdata, d_rdata, 32'h0};
      checks++;
      if (got != '0) begin
         failures++;
         $display("FAIL %s outputs=%h required all zero", name, got);
      end
   endtask

   // Clock and cycle counter.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory model: returns mem_f(addr) exactly MemLatency cycles after mem_en, junk otherwise.
   initial begin
      logic        rd_pend;
      int          rd_due;
      logic [15:0] rd_addr;
      rd_pend   = 1'b0;
      rd_due    = 0;
      rd_addr   = 16'h0;
      mem_rdata = 32'hBAD0_BAD0;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            rd_pend = 1'b1;
            rd_due  = cyc + MemLatency;
            rd_addr = mem_addr;
         end
         @(posedge clk);
         #1;
         if (rd_pend && cyc == rd_due) begin
            mem_rdata = mem_f(rd_addr);
            rd_pend   = 1'b0;
         end else begin
            mem_rdata = {16'hBAD0, cyc[15:0]};
         end
      end
   end

   // Monitor: strobe invariants every cycle, scoreboard pop on each gnt/rvalid.
   initial begin
      forever begin
         @(negedge clk);
         checks++;
         if ((mem_en != (if_gnt | d_gnt)) || (if_gnt && d_gnt)) begin
            failures++;
            $display("FAIL strobe_invariant cyc=%0d mem_en=%b if_gnt=%b d_gnt=%b, required mem_en=gnt, one gnt",
                     cyc, mem_en, if_gnt, d_gnt);
         end
         if (if_gnt)    check_event(KIfGnt);
         if (d_gnt)     check_event(KDGnt);
         if (if_rvalid) check_event(KIfRv);
         if (d_rvalid)  check_event(KDRv);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      rst     = 1'b1;
      if_req  = 1'b0;
      if_addr = 16'h0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 16'h0;
      d_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle_outputs("reset_state");

      // Lone fetch.
      sync(c);
      push(c + 1, KIfGnt, 16'h0010, 1'b0, 32'h0);
      push(c + 4, KIfRv, 16'h0010, 1'b0, mem_f(16'h0010));
      issue_if(16'h0010);
      settle("fetch_only");

      // Tie: data load first, fetch in the idle cycle that carries d_rvalid.
      sync(c);
      push(c + 1, KDGnt, 16'h0100, 1'b0, 32'h0);
      push(c + 4, KDRv, 16'h0100, 1'b0, mem_f(16'h0100));
      push(c + 5, KIfGnt, 16'h0200, 1'b0, 32'h0);
      push(c + 8, KIfRv, 16'h0200, 1'b0, mem_f(16'h0200));
      d_last = mem_f(16'h0100);
      fork
         issue_d(16'h0100, 1'b0, 32'h0);
         issue_if(16'h0200);
      join
      settle("tie_data_first");

      // Store: completion pulses, load data untouched.
      sync(c);
      push(c + 1, KDGnt, 16'h0020, 1'b1, 32'hDEADBEEF);
      push(c + 4, KDRv, 16'h0020, 1'b1, d_last);
      issue_d(16'h0020, 1'b1, 32'hDEADBEEF);
      settle("store");

      // Load after store.
      sync(c);
      push(c + 1, KDGnt, 16'h0030, 1'b0, 32'h0);
      push(c + 4, KDRv, 16'h0030, 1'b0, mem_f(16'h0030));
      d_last = mem_f(16'h0030);
      issue_d(16'h0030, 1'b0, 32'h0);
      settle("load");

      // Both held for ten back-to-back accesses, one every four cycles.
      sync(c);
      if_addr = 16'h0300;
      d_addr  = 16'h0400;
      d_we    = 1'b0;
      if_req  = 1'b1;
      d_req   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (StarveEn && (k % 5 == 4)) begin
            push(c + 1 + 4 * k, KIfGnt, 16'h0300, 1'b0, 32'h0);
            push(c + 4 + 4 * k, KIfRv, 16'h0300, 1'b0, mem_f(16'h0300));
         end else begin
            push(c + 1 + 4 * k, KDGnt, 16'h0400, 1'b0, 32'h0);
            push(c + 4 + 4 * k, KDRv, 16'h0400, 1'b0, mem_f(16'h0400));
         end
      end
      repeat (38) @(posedge clk);
      #1;
      if_req = 1'b0;
      d_req  = 1'b0;
      settle("both_held");

      // Reset in the wait state: access abandoned, no rvalid, rdata cleared.
      sync(c);
      push(c + 1, KIfGnt, 16'h0050, 1'b0, 32'h0);
      if_addr = 16'h0050;
      if_req  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if_req = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle_outputs("reset_in_wait");
      d_last = 32'h0;
      settle("reset_in_wait_quiet");

      // Normal service after reset.
      sync(c);
      push(c + 1, KIfGnt, 16'h0060, 1'b0, 32'h0);
      push(c + 4, KIfRv, 16'h0060, 1'b0, mem_f(16'h0060));
      issue_if(16'h0060);
      settle("after_reset");

      // A data request raised and dropped while busy never gets granted.
      sync(c);
      push(c + 1, KIfGnt, 16'h0070, 1'b0, 32'h0);
      push(c + 4, KIfRv, 16'h0070, 1'b0, mem_f(16'h0070));
      if_addr = 16'h0070;
      if_req  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if_req = 1'b0;
      d_addr = 16'h0080;
      d_we   = 1'b0;
      d_req  = 1'b1;
      @(posedge clk);
      #1;
      d_req = 1'b0;
      settle("dropped_req");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
